// File: rtl/wb_data_ram_if.sv
// Wishbone classic data-port bundle between the openmips data master and wb_data_ram.
interface wb_data_ram_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [SEL_W-1:0]  wb_sel_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_data_ram.sv
// Wishbone-slave data RAM with configurable wait states and registered read/ack.
// Define WB_RAM_ADDR_ERR_EN to answer out-of-range addresses with wb_err_o instead of aliasing.
module wb_data_ram #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic          clk,
    input logic          rst,
    wb_data_ram_if.slave wb
);
    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned AL    = $clog2(SEL_W);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [SEL_W-1:0]        sel_q;
    logic [DATA_W-1:0]       wdat_q;
    logic                    oor_q;
    logic                    ack_q;
    logic                    err_q;
    logic [DATA_W-1:0]       dat_q;

    logic [DATA_W-1:0]       mem [DEPTH];

    logic                    req;
    logic                    in_oor;
    logic                    unused_adr;
    logic                    commit;
    logic                    we_d;
    logic [DEPTH_LOG2-1:0]   idx_d;
    logic [SEL_W-1:0]        sel_d;
    logic [DATA_W-1:0]       wdat_d;
    logic                    oor_d;

    always_comb begin
        req        = wb.wb_cyc_i && wb.wb_stb_i;
        unused_adr = ^wb.wb_adr_i;
`ifdef WB_RAM_ADDR_ERR_EN
        in_oor     = |wb.wb_adr_i[ADDR_W-1:DEPTH_LOG2+AL];
`else
        in_oor     = 1'b0;
`endif
    end

    // With zero wait states the commit edge is the capture edge, so the
    // transfer attributes come straight from the bus while in IDLE.
    always_comb begin
        we_d   = we_q;
        idx_d  = idx_q;
        sel_d  = sel_q;
        wdat_d = wdat_q;
        oor_d  = oor_q;
        commit = 1'b0;
        case (state_q)
            IDLE: begin
                we_d   = wb.wb_we_i;
                idx_d  = wb.wb_adr_i[DEPTH_LOG2+AL-1:AL];
                sel_d  = wb.wb_sel_i;
                wdat_d = wb.wb_dat_i;
                oor_d  = in_oor;
                commit = req && (WAIT_STATES == 0);
            end
            WAIT:    commit = wb.wb_cyc_i && (cnt_q == 4'd1);
            default: commit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit && we_d && !oor_d) begin
            for (int unsigned i = 0; i < SEL_W; i++) begin
                if (sel_d[i]) mem[idx_d][8*i +: 8] <= wdat_d[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            wdat_q  <= '0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= we_d;
                        idx_q   <= idx_d;
                        sel_q   <= sel_d;
                        wdat_q  <= wdat_d;
                        oor_q   <= oor_d;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= (WAIT_STATES == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (!wb.wb_cyc_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= ACK;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (commit) begin
                ack_q <= ~oor_d;
                err_q <= oor_d;
                dat_q <= (we_d || oor_d) ? '0 : mem[idx_d];
            end
        end
    end

    always_comb begin
        wb.wb_ack_o = ack_q;
        wb.wb_err_o = err_q;
        wb.wb_dat_o = dat_q;
    end
endmodule

// File: tb/tb_wb_data_ram.sv
// Scoreboard bench for wb_data_ram: four instances with different wait states share one bus driver.
module tb_wb_data_ram;
    localparam int NDUT = 4;
    localparam int WS_TAB [NDUT] = '{1, 0, 3, 2};

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    int          dsel;

    logic [NDUT-1:0]       ack_v, err_v;
    logic [NDUT-1:0][31:0] dat_v;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        wb_data_ram_if #(.DATA_W(32), .ADDR_W(32)) bus ();
        assign bus.wb_cyc_i = cyc && (dsel == g);
        assign bus.wb_stb_i = stb && (dsel == g);
        assign bus.wb_we_i  = we;
        assign bus.wb_adr_i = adr;
        assign bus.wb_sel_i = sel;
        assign bus.wb_dat_i = dat;
        assign ack_v[g]     = bus.wb_ack_o;
        assign err_v[g]     = bus.wb_err_o;
        assign dat_v[g]     = bus.wb_dat_o;
        wb_data_ram #(
            .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_STATES(WS_TAB[g])
        ) dut (
            .clk(clk), .rst(rst), .wb(bus)
        );
    end

    int          n_checks, n_fail;
    bit          busy;
    int unsigned ncyc = 0;
    int unsigned last_resp;
    logic [31:0] model [NDUT][1024];
    exp_t        sbq [$];

    always @(posedge clk) ncyc <= ncyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1);
    end

    // Entered just after a falling edge; returns at the falling edge where the response was seen.
    task automatic do_xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rdata, output bit rerr);
        exp_t        e, got;
        bit          done;
        int unsigned idx;
        idx   = 32'(a[11:2]);
        e.err = 1'b0;
`ifdef WB_RAM_ADDR_ERR_EN
        e.err = |a[31:12];
`endif
        e.rd  = !w;
        e.lat = WS_TAB[dsel] + (busy ? 2 : 1);
        if (w && !e.err)
            for (int b = 0; b < 4; b++) if (s[b]) model[dsel][idx][8*b +: 8] = d[8*b +: 8];
        e.data = (w || e.err) ? 32'h0 : model[dsel][idx];
        sbq.push_back(e);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        done = 1'b0; rdata = '0; rerr = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (ack_v[dsel] || err_v[dsel]) begin
                done = 1'b1;
                got = sbq.pop_front();
                last_resp = ncyc;
                n_checks++;
                if ({ack_v[dsel], err_v[dsel]} !== {~got.err, got.err}) begin
                    n_fail++;
                    $display("FAIL resp_kind dut%0d adr=%h: ack,err=%b%b required %b%b",
                             dsel, a, ack_v[dsel], err_v[dsel], ~got.err, got.err);
                end
                n_checks++;
                if (k != got.lat) begin
                    n_fail++;
                    $display("FAIL latency dut%0d adr=%h: %0d cycles, required %0d", dsel, a, k, got.lat);
                end
                if (got.rd || got.err) begin
                    n_checks++;
                    if (dat_v[dsel] !== got.data) begin
                        n_fail++;
                        $display("FAIL rdata dut%0d adr=%h: got %h required %h", dsel, a, dat_v[dsel], got.data);
                    end
                end
                rdata = dat_v[dsel];
                rerr  = err_v[dsel];
            end else begin
                n_checks++;
                if (dat_v[dsel] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL dat_outside_ack dut%0d: got %h required 0", dsel, dat_v[dsel]);
                end
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL timeout dut%0d adr=%h: no ack/err within 40 cycles", dsel, a);
            void'(sbq.pop_front());
        end
        busy = 1'b1;
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack_v !== '0 || err_v !== '0 || dat_v[dsel] !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_after_resp: ack=%b err=%b dat=%h required 0/0/0", ack_v, err_v, dat_v[dsel]);
        end
        busy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ack_v !== '0 || err_v !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: ack=%b err=%b required 0", ack_v, err_v);
        end
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (dat_v[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_dat dut%0d: got %h required 0", i, dat_v[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_byte_lanes();
        logic [31:0] r; bit e;
        dsel = 0;
        do_xfer(1'b1, 32'h20, 4'b1111, 32'h11223344, r, e); idle_bus();
        do_xfer(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, r, e); idle_bus();
        do_xfer(1'b0, 32'h20, 4'b1111, 32'h0, r, e); idle_bus();
        n_checks++;
        if (r !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL byte_lanes: got %h required 11bb33dd", r);
        end
        do_xfer(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, r, e); idle_bus();
        do_xfer(1'b0, 32'h23, 4'b0000, 32'h0, r, e); idle_bus();
        n_checks++;
        if (r !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL sel_zero_write: got %h required 11bb33dd", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; bit e; int unsigned t0;
        dsel = 1;
        do_xfer(1'b1, 32'h4, 4'b1111, 32'hCAFEF00D, r, e);
        t0 = last_resp;
        do_xfer(1'b0, 32'h4, 4'b1111, 32'h0, r, e);
        n_checks++;
        if (last_resp - t0 != 2) begin
            n_fail++; $display("FAIL ack_spacing: %0d cycles between acks, required 2", last_resp - t0);
        end
        n_checks++;
        if (r !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL raw_ws0: got %h required cafef00d", r);
        end
        idle_bus();
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] r; bit e, seen;
        dsel = 2;
        do_xfer(1'b1, 32'h10, 4'b1111, 32'h01020304, r, e); idle_bus();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; sel = 4'b1111; dat = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (ack_v !== '0 || err_v !== '0 || dat_v[2] !== 32'h0) begin
            n_fail++; $display("FAIL reset_in_wait: ack=%b err=%b dat=%h required all 0", ack_v, err_v, dat_v[2]);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack_v != '0 || err_v != '0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL ack_after_reset: saw ack/err=1 required none");
        end
        do_xfer(1'b0, 32'h10, 4'b1111, 32'h0, r, e); idle_bus();
        n_checks++;
        if (r !== 32'h01020304) begin
            n_fail++; $display("FAIL dropped_write: got %h required 01020304", r);
        end
    endtask

    task automatic test_abort();
        logic [31:0] r; bit e, seen, got;
        dsel = 3;
        do_xfer(1'b1, 32'h40, 4'b1111, 32'h13572468, r, e); idle_bus();
        for (int pass = 0; pass < 2; pass++) begin
            cyc = 1'b1; stb = 1'b1; we = (pass == 1); adr = 32'h40; sel = 4'b1111; dat = 32'hFFFFFFFF;
            @(negedge clk);
            cyc = 1'b0; stb = 1'b0;
            seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (ack_v != '0 || err_v != '0) seen = 1'b1;
            end
            n_checks++;
            if (seen) begin
                n_fail++; $display("FAIL abort_resp pass%0d: saw ack/err=1 required none", pass);
            end
        end
        do_xfer(1'b0, 32'h40, 4'b1111, 32'h0, r, e); idle_bus();
        n_checks++;
        if (r !== 32'h13572468) begin
            n_fail++; $display("FAIL abort_write: got %h required 13572468", r);
        end
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h44; sel = 4'b1111; dat = 32'h2468ACE0;
        model[3][17] = 32'h2468ACE0;
        @(negedge clk);
        stb = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (ack_v[3]) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL stb_drop: ack=0 required 1 within 10 cycles");
        end
        idle_bus();
        do_xfer(1'b0, 32'h44, 4'b1111, 32'h0, r, e); idle_bus();
    endtask

    task automatic test_addr_range();
        logic [31:0] r, exp_r; bit e, exp_e;
`ifdef WB_RAM_ADDR_ERR_EN
        exp_e = 1'b1; exp_r = 32'h12345678;
`else
        exp_e = 1'b0; exp_r = 32'h5A5A5A5A;
`endif
        dsel = 0;
        do_xfer(1'b1, 32'h0, 4'b1111, 32'h12345678, r, e); idle_bus();
        do_xfer(1'b1, 32'h1000, 4'b1111, 32'h5A5A5A5A, r, e); idle_bus();
        n_checks++;
        if (e !== exp_e) begin
            n_fail++; $display("FAIL range_err: err=%b required %b", e, exp_e);
        end
        do_xfer(1'b0, 32'h0, 4'b1111, 32'h0, r, e); idle_bus();
        n_checks++;
        if (r !== exp_r) begin
            n_fail++; $display("FAIL range_alias: got %h required %h", r, exp_r);
        end
    endtask

    task automatic test_soak();
        logic [31:0] r, a; bit e;
        dsel = 0;
        for (int w = 0; w < 16; w++) begin
            do_xfer(1'b1, 32'(w * 4), 4'b1111, $urandom, r, e); idle_bus();
        end
        for (int n = 0; n < 200; n++) begin
            a = {($urandom_range(0, 3) == 0) ? 20'($urandom_range(1, 20'hFFFFF)) : 20'h0,
                 6'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            do_xfer(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, r, e);
            n_checks++;
            if (ack_v[0] && err_v[0]) begin
                n_fail++; $display("FAIL soak_onehot: ack=1 err=1 required one-hot");
            end
            if ($urandom_range(0, 2) != 0) idle_bus();
        end
        idle_bus();
    endtask

    initial begin
        n_checks = 0; n_fail = 0; busy = 1'b0; dsel = 0; last_resp = 0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0; rst = 1'b1;
        test_reset();
        test_byte_lanes();
        test_back_to_back();
        test_reset_mid_wait();
        test_abort();
        test_addr_range();
        test_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
